// File: rtl/pwm_multi_pkg.sv
// Shared types and default sizing for the multi-channel PWM generator.
// The PWM_NCH / PWM_RES macros can be predefined by the build to resize the
// block. Otherwise the defaults below apply.
`ifndef PWM_NCH
`define PWM_NCH 2
`endif
`ifndef PWM_RES
`define PWM_RES 8
`endif

package pwm_multi_pkg;

  localparam int DEF_NCH        = `PWM_NCH;
  localparam int DEF_NBITS      = `PWM_RES;
  localparam int DEF_PRESC_BITS = 16;

  // Counting direction of the timebase. Edge-aligned mode always counts up.
  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  // Waveform shape. It is latched only at a period boundary.
  typedef enum logic {
    MODE_EDGE   = 1'b0,
    MODE_CENTER = 1'b1
  } mode_e;

endpackage

// File: rtl/pwm_multi_timebase.sv
// Shared PWM timebase: a runtime prescaler feeding a saw (edge-aligned) or
// triangle (center-aligned) counter. It reports the period boundary, which is
// the tick where the counter returns to zero. The prescaler value and the mode
// are sampled only at a boundary, so a change never shortens or stretches a
// period that is already running.
module pwm_multi_timebase
  import pwm_multi_pkg::*;
#(
  parameter int NBITS      = DEF_NBITS,
  parameter int PRESC_BITS = DEF_PRESC_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [PRESC_BITS-1:0] presc,
  input  logic                  center,
  output logic [NBITS-1:0]      cnt,
  output logic                  boundary
);

  localparam logic [NBITS-1:0] CNT_MAX = '1;

  logic [PRESC_BITS-1:0] pcnt;
  logic [PRESC_BITS-1:0] presc_act;
  mode_e                 mode;
  dir_e                  dir;
  dir_e                  dir_next;
  logic [NBITS-1:0]      cnt_next;
  logic                  armed;
  logic                  tick;

  // When the prescaler count reaches the active prescaler value, the counter
  // advances by one step.
  assign tick = en && (pcnt == presc_act);

  // The next counter value comes from the current mode and direction. In the
  // triangle, turning at MAX goes straight to MAX-1, so no endpoint is
  // repeated.
  always_comb begin
    cnt_next = cnt + NBITS'(1);
    dir_next = dir;
    if (mode == MODE_CENTER) begin
      if (dir == DIR_UP) begin
        if (cnt == CNT_MAX) begin
          cnt_next = cnt - NBITS'(1);
          dir_next = DIR_DOWN;
        end
      end else begin
        cnt_next = cnt - NBITS'(1);
      end
    end
  end

  // A boundary is a tick that brings the counter back to zero. While armed
  // (after reset or en low), the first tick is a boundary so the
  // configuration loads before any period runs.
  assign boundary = tick && (armed || (cnt_next == '0));

  // This block holds the prescaler, the counter and direction, and the
  // configuration latched at each boundary.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pcnt      <= '0;
      cnt       <= '0;
      dir       <= DIR_UP;
      armed     <= 1'b1;
      presc_act <= '0;
      mode      <= MODE_EDGE;
    end else if (!en) begin
      pcnt  <= '0;
      cnt   <= '0;
      dir   <= DIR_UP;
      armed <= 1'b1;
    end else if (tick) begin
      pcnt <= '0;
      if (boundary) begin
        cnt       <= '0;
        dir       <= DIR_UP;
        armed     <= 1'b0;
        presc_act <= presc;
        mode      <= center ? MODE_CENTER : MODE_EDGE;
      end else begin
        cnt <= cnt_next;
        dir <= dir_next;
      end
    end else begin
      pcnt <= pcnt + PRESC_BITS'(1);
    end
  end

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM generator. All channels share one timebase. Each channel
// has a shadow duty register and an active duty register. A write lands in
// shadow and is copied to active only at a period boundary, so an output
// never glitches mid-period. A write that arrives on the boundary clock goes
// straight to active.
module pwm_multi
  import pwm_multi_pkg::*;
#(
  parameter int NCH        = DEF_NCH,
  parameter int NBITS      = DEF_NBITS,
  parameter int PRESC_BITS = DEF_PRESC_BITS
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [PRESC_BITS-1:0]     presc,
  input  logic                      center,
  input  logic [NCH-1:0]            pol,
  input  logic [NCH*(NBITS+1)-1:0]  duty,
  input  logic                      duty_wr,
  output logic [NCH-1:0]            out,
  output logic                      period_start,
  output logic                      pending
);

  localparam int DW = NBITS + 1;

  logic [NBITS-1:0] cnt;
  logic             boundary;
  logic [NCH-1:0]   raw;

  pwm_multi_timebase #(
    .NBITS      (NBITS),
    .PRESC_BITS (PRESC_BITS)
  ) u_timebase (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .presc    (presc),
    .center   (center),
    .cnt      (cnt),
    .boundary (boundary)
  );

  // The period_start pulse and the pending flag. A boundary clears pending
  // even when a write lands on the same clock, because that write bypasses
  // shadow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      period_start <= 1'b0;
      pending      <= 1'b0;
    end else begin
      period_start <= boundary;
      if (boundary) begin
        pending <= 1'b0;
      end else if (duty_wr) begin
        pending <= 1'b1;
      end
    end
  end

  for (genvar ch = 0; ch < NCH; ch++) begin : gen_ch
    logic [DW-1:0] incoming;
    logic [DW-1:0] shadow;
    logic [DW-1:0] active;

    assign incoming = duty[ch*DW +: DW];

    // Each channel has a shadow and an active duty register. Active changes
    // only at a boundary. It takes a coincident write directly, or otherwise
    // the pending shadow value.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        shadow <= '0;
        active <= '0;
      end else begin
        if (duty_wr) begin
          shadow <= incoming;
        end
        if (boundary) begin
          if (duty_wr) begin
            active <= incoming;
          end else if (pending) begin
            active <= shadow;
          end
        end
      end
    end

    // The extra duty bit allows 100%: any duty of 2**NBITS or more is above
    // every count value.
    assign raw[ch] = ({1'b0, cnt} < active);
  end

  // The outputs are registered. While disabled, each output sits at its
  // inactive level, which is the polarity bit itself.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out <= '0;
    end else begin
      out <= (en ? raw : '0) ^ pol;
    end
  end

endmodule
